// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//
// Receives a program image over a UART line (8N1, or 8E1 when parity is
// enabled) and writes it into instruction memory one 32-bit word at a time.
// Bytes are assembled little-endian. A session is armed by a one-cycle
// 'start' pulse. It ends after the all-zero terminator word has been written,
// or after the last memory word has been written.
//
// Optional feature: define LOADER_PARITY_EN to expect an even-parity bit
// between data bit 7 and the stop bit.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit
//   ADDR_W        instruction-memory word address width
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   rx_in       asynchronous serial input, idle high
//   start       one-cycle pulse that arms a load session
//   imem_we     instruction-memory write strobe (one cycle per word)
//   imem_addr   instruction-memory word address
//   imem_wdata  instruction word to write
//   loading     high while a session is active (core held off)
//   done        sticky high once the image is complete
//   err         sticky high after any framing/parity error (cleared by rst only)
// -----------------------------------------------------------------------------
module instr_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              loading,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'((CLKS_PER_BIT / 2 > 0) ? (CLKS_PER_BIT / 2 - 1) : 0);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef LOADER_PARITY_EN
        RX_PAR,
`endif
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_RECV,
        LD_WRITE,
        LD_DONE
    } ld_state_t;

    // Synchronizer plus one history flop used for falling-edge start detection.
    logic              rx_meta_reg;
    logic              rx_sync_reg;
    logic              rx_prev_reg;

    rx_state_t         rx_state_reg;
    logic [CNT_W-1:0]  baud_cnt_reg;
    logic [2:0]        bit_cnt_reg;
    logic [7:0]        shift_reg;
`ifdef LOADER_PARITY_EN
    logic              par_bad_reg;
`endif

    ld_state_t         ld_state_reg;
    logic [1:0]        byte_cnt_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic              loading_reg;
    logic              done_reg;
    logic              err_reg;

    logic              stop_sample;
    logic              byte_ok;

    assign stop_sample = (rx_state_reg == RX_STOP) && (baud_cnt_reg == BIT_LAST);
`ifdef LOADER_PARITY_EN
    assign byte_ok = stop_sample && rx_sync_reg && !par_bad_reg;
`else
    assign byte_ok = stop_sample && rx_sync_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= RX_IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
`ifdef LOADER_PARITY_EN
            par_bad_reg  <= 1'b0;
`endif
            ld_state_reg <= LD_IDLE;
            byte_cnt_reg <= '0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            loading_reg  <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            rx_meta_reg <= rx_in;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;

            // ---------------- receiver ----------------
            case (rx_state_reg)
                RX_IDLE: begin
                    baud_cnt_reg <= '0;
                    bit_cnt_reg  <= '0;
                    // Falling edge, not level: after a framing error the line
                    // may still be low and must not be taken as a new start.
                    if (loading_reg && rx_prev_reg && !rx_sync_reg)
                        rx_state_reg <= RX_START;
                end
                RX_START: begin
                    if (baud_cnt_reg == HALF_LAST) begin
                        baud_cnt_reg <= '0;
                        rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
`ifdef LOADER_PARITY_EN
                        par_bad_reg  <= 1'b0;
`endif
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (baud_cnt_reg == BIT_LAST) begin
                        baud_cnt_reg <= '0;
                        shift_reg    <= {rx_sync_reg, shift_reg[7:1]};
                        bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == 3'd7) begin
`ifdef LOADER_PARITY_EN
                            rx_state_reg <= RX_PAR;
`else
                            rx_state_reg <= RX_STOP;
`endif
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
`ifdef LOADER_PARITY_EN
                RX_PAR: begin
                    // Still walk through the stop bit so the parity-error
                    // byte ends with the line back at idle.
                    if (baud_cnt_reg == BIT_LAST) begin
                        baud_cnt_reg <= '0;
                        par_bad_reg  <= (rx_sync_reg != ^shift_reg);
                        rx_state_reg <= RX_STOP;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
`endif
                RX_STOP: begin
                    if (stop_sample) begin
                        baud_cnt_reg <= '0;
                        rx_state_reg <= RX_IDLE;
                        if (!byte_ok)
                            err_reg <= 1'b1;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase

            // ---------------- loader ----------------
            case (ld_state_reg)
                LD_IDLE, LD_DONE: begin
                    we_reg <= 1'b0;
                    if (start) begin
                        ld_state_reg <= LD_RECV;
                        addr_reg     <= '0;
                        byte_cnt_reg <= '0;
                        done_reg     <= 1'b0;
                        loading_reg  <= 1'b1;
                    end
                end
                LD_RECV: begin
                    we_reg <= 1'b0;
                    if (byte_ok) begin
                        wdata_reg[{byte_cnt_reg, 3'b000} +: 8] <= shift_reg;
                        byte_cnt_reg <= byte_cnt_reg + 1'b1;
                        if (byte_cnt_reg == 2'd3) begin
                            ld_state_reg <= LD_WRITE;
                            we_reg       <= 1'b1;
                        end
                    end
                end
                LD_WRITE: begin
                    we_reg <= 1'b0;
                    // The terminator word is written before stopping.
                    if (wdata_reg == 32'h0 || addr_reg == ADDR_LAST) begin
                        ld_state_reg <= LD_DONE;
                        done_reg     <= 1'b1;
                        loading_reg  <= 1'b0;
                    end else begin
                        ld_state_reg <= LD_RECV;
                        addr_reg     <= addr_reg + 1'b1;
                        byte_cnt_reg <= '0;
                    end
                end
                default: begin
                    ld_state_reg <= LD_IDLE;
                    we_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign imem_we    = we_reg;
    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    assign loading    = loading_reg;
    assign done       = done_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
//
// Scoreboard bench for instr_loader (CLKS_PER_BIT=4, ADDR_W=5). Stimulus tasks
// drive serial bytes and update a word-level model of a load session; the
// model pushes each expected memory write into a queue. A monitor on the
// falling clock edge pops and compares every imem_we cycle it sees.
// Compile with LOADER_PARITY_EN defined to exercise the parity variant.
// -----------------------------------------------------------------------------
module tb_instr_loader;

    localparam int CPB = 4;
    localparam int AW  = 5;
    localparam int LAST_ADDR = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic          start;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          loading;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    instr_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .start      (start),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .loading    (loading),
        .done       (done),
        .err        (err)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];

    // ---------------- reference model (session level) ----------------
    bit          m_loading = 0;
    bit          m_done    = 0;
    bit          m_err     = 0;
    int          m_addr    = 0;
    logic [7:0]  m_bytes[$];

    function automatic void m_reset();
        m_loading = 0;
        m_done    = 0;
        m_err     = 0;
        m_addr    = 0;
        m_bytes.delete();
        exp_q.delete();
    endfunction

    function automatic void m_start();
        if (!m_loading) begin
            m_loading = 1;
            m_done    = 0;
            m_addr    = 0;
            m_bytes.delete();
        end
    endfunction

    function automatic void m_byte(logic [7:0] b, bit ok);
        logic [31:0] word;
        wr_t         w;
        if (!m_loading) return;
        if (!ok) begin
            m_err = 1;
            return;
        end
        m_bytes.push_back(b);
        if (m_bytes.size() == 4) begin
            word   = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
            w.addr = m_addr;
            w.data = word;
            exp_q.push_back(w);
            m_bytes.delete();
            if (word == 32'h0 || m_addr == LAST_ADDR) begin
                m_loading = 0;
                m_done    = 1;
            end else begin
                m_addr++;
            end
        end
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: addr %0d data 0x%08h, expected no write",
                         imem_addr, imem_wdata);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("write_addr", 32'(imem_addr), 32'(w.addr));
                check("write_data", imem_wdata, w.data);
                $display("write addr=%0d data=0x%08h (expected addr=%0d data=0x%08h)",
                         imem_addr, imem_wdata, w.addr, w.data);
            end
        end
    end

    task automatic check_status(input string tag);
        check({tag, "_done"},    32'(done),    32'(m_done));
        check({tag, "_loading"}, 32'(loading), 32'(m_loading));
        check({tag, "_err"},     32'(err),     32'(m_err));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1, input bit par_ok = 1'b1);
        // Model first: the write lands inside the stop bit.
        m_byte(b, stop_ok && par_ok);
        rx_in = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            tick(CPB);
        end
`ifdef LOADER_PARITY_EN
        rx_in = (^b) ^ !par_ok;
        tick(CPB);
`endif
        rx_in = stop_ok;
        tick(CPB);
        rx_in = 1'b1;
        tick(2 * CPB);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        m_start();
        tick(1);
        start = 1'b0;
        tick(2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        m_reset();
        rst = 1'b0;
        tick(1);
    endtask

    function automatic logic [31:0] rand_nz();
        logic [31:0] w;
        w = $urandom;
        if (w == 32'h0) w = 32'h1;
        return w;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        rx_in = 1'b1;
        start = 1'b0;
        tick(3);
        m_reset();
        rst = 1'b0;
        tick(1);

        // Reset state
        check("rst_we",      32'(imem_we),   32'd0);
        check("rst_addr",    32'(imem_addr), 32'd0);
        check("rst_wdata",   imem_wdata,     32'd0);
        check("rst_loading", 32'(loading),   32'd0);
        check("rst_done",    32'(done),      32'd0);
        check("rst_err",     32'(err),       32'd0);

        // Bytes before start are ignored
        send_byte(8'h55);
        check_status("prestart");

        // Two-word program ending in the terminator
        pulse_start();
        check("armed_loading", 32'(loading), 32'd1);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
        send_word(32'h0);
        tick(4);
        check_status("basic");

        // Framing error, then a good word at address 0
        pulse_start();
        send_byte(8'h13, 1'b0);
        check("framing_err", 32'(err), 32'd1);
        send_word(rand_nz());
        send_word(32'h0);
        tick(4);
        check_status("framing");

        do_reset();
        check("rst_clears_err", 32'(err), 32'd0);

        // One-cycle glitch in idle
        pulse_start();
        rx_in = 1'b0;
        tick(1);
        rx_in = 1'b1;
        tick(4 * CPB);
        check_status("glitch");
        send_word(rand_nz());
        send_word(32'h0);
        tick(4);
        check_status("after_glitch");

        // Full memory, then a 33rd word that must be ignored
        do_reset();
        pulse_start();
        for (int i = 0; i <= LAST_ADDR; i++) send_word(rand_nz());
        tick(4);
        check_status("full");
        send_word(rand_nz());
        tick(4);
        check_status("overflow");

        // Reset mid-word discards the partial data
        do_reset();
        pulse_start();
        send_byte(8'h11); send_byte(8'h22);
        do_reset();
        pulse_start();
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        tick(4);
        check_status("midword_rst");
        send_word(32'h0);
        tick(4);
        check_status("midword_end");

`ifdef LOADER_PARITY_EN
        // Parity: bad parity discards, good parity accepts
        do_reset();
        pulse_start();
        send_byte(8'h01, 1'b1, 1'b0);
        check("parity_err", 32'(err), 32'd1);
        send_byte(8'h01, 1'b1, 1'b1);
        send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_word(32'h0);
        tick(4);
        check_status("parity");
`endif

        // Random sessions, with ignored start pulses and occasional bad bytes
        do_reset();
        for (int s = 0; s < 4; s++) begin
            int nw;
            pulse_start();
            nw = int'($urandom_range(1, 5));
            for (int k = 0; k < nw; k++) begin
                logic [31:0] w;
                w = rand_nz();
                for (int i = 0; i < 4; i++) begin
                    if ($urandom_range(0, 9) == 0) send_byte(8'($urandom), 1'b0);
                    if ($urandom_range(0, 7) == 0) pulse_start();
                    send_byte(w[8*i +: 8]);
                end
            end
            send_word(32'h0);
            tick(4);
            check_status("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clk cycles per serial bit (50 MHz / 115200 baud).
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the instruction-memory word address width (32 words).
REQ-003 The block SHALL have port clk, input, 1, system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-005 The block SHALL have port rx_in, input, 1, asynchronous serial line, idle high.
REQ-006 The block SHALL have port start, input, 1, one-cycle pulse that arms a load session.
REQ-007 The block SHALL have port imem_we, output, 1, instruction-memory write strobe.
REQ-008 The block SHALL have port imem_addr, output, ADDR_W, instruction-memory word address.
REQ-009 The block SHALL have port imem_wdata, output, 32, instruction word to write.
REQ-010 The block SHALL have port loading, output, 1, high while a session is active; the core is held off while high.
REQ-011 The block SHALL have port done, output, 1, sticky high when the program image is complete.
REQ-012 The block SHALL have port err, output, 1, sticky high after any framing or parity error.

Function
REQ-013 rx_in SHALL pass through a two-flop synchronizer before use; the synchronizer resets to 1.
REQ-014 The receiver FSM SHALL have states RX_IDLE, RX_START, RX_DATA, RX_PAR (present only with the macro), and RX_STOP.
REQ-015 In RX_IDLE, a synchronized 0 SHALL move the receiver to RX_START; only when loading=1.
REQ-016 RX_START SHALL resample at CLKS_PER_BIT/2 cycles; a 1 returns to RX_IDLE (glitch), a 0 moves to RX_DATA.
REQ-017 RX_DATA SHALL sample 8 bits LSB-first, each CLKS_PER_BIT cycles after the previous sample point.
REQ-018 RX_STOP SHALL sample CLKS_PER_BIT after the last data/parity sample; a 1 accepts the byte, a 0 sets err, discards the byte and leaves the byte count unchanged; either way it returns to RX_IDLE.
REQ-019 The loader FSM SHALL have states LD_IDLE, LD_RECV, LD_WRITE, LD_DONE.
REQ-020 LD_IDLE + start SHALL go to LD_RECV with imem_addr=0, byte count=0, done=0; loading=1 from the next cycle.
REQ-021 Accepted bytes SHALL assemble little-endian: byte 0 to bits [7:0] through byte 3 to bits [31:24].
REQ-022 On the 4th accepted byte, the FSM SHALL enter LD_WRITE; imem_we=1 for exactly one cycle, the cycle after stop-bit acceptance, with imem_wdata/imem_addr stable in that cycle.
REQ-023 After the write, if the word was 0x00000000 or imem_addr was 2^ADDR_W-1, the FSM SHALL go to LD_DONE; otherwise imem_addr increments, byte count clears, and it returns to LD_RECV.
REQ-024 The terminator word 0x00000000 SHALL itself be written, so the core halts on it.
REQ-025 imem_addr SHALL never wrap; bytes arriving in LD_DONE SHALL be ignored.
REQ-026 LD_DONE SHALL hold done=1 and loading=0; start in LD_DONE SHALL begin a new session (REQ-020); err is not cleared by start.
REQ-027 start during LD_RECV or LD_WRITE SHALL be ignored.
REQ-028 imem_we SHALL be 0 in every state except LD_WRITE.

Reset
REQ-029 rst SHALL force LD_IDLE and RX_IDLE and set imem_we=0, imem_addr=0, imem_wdata=0, loading=0, done=0, err=0, byte count=0, and the bit counter and baud counter to 0.
REQ-030 rst mid-byte or mid-word SHALL discard the partial data; no write occurs in the reset cycle or after it until the next 4 accepted bytes.

Configuration
REQ-031 With LOADER_PARITY_EN defined, an even-parity bit SHALL follow the data bits (RX_PAR); a mismatch sets err and discards the byte as in REQ-018.
REQ-032 Without LOADER_PARITY_EN, RX_PAR SHALL not exist and the stop bit SHALL immediately follow data bit 7.

Verification (CLKS_PER_BIT=4, ADDR_W=5)
REQ-033 The bench SHALL cover the following: start, bytes 93 00 50 00 then 00 00 00 00 -> imem_we at addr 0 data 0x00500093, then addr 1 data 0x00000000, done=1, loading=0.
REQ-034 The bench SHALL cover the following: byte 0x13 with stop bit 0 -> err=1, no write; the next 4 good bytes are written to addr 0.
REQ-035 The bench SHALL cover the following: a 1-cycle low glitch on rx_in in RX_IDLE -> no byte accepted, err=0.
REQ-036 The bench SHALL cover the following: 32 nonzero words -> last write at addr 31, then done=1; a 33rd word produces no imem_we.
REQ-037 The bench SHALL cover the following: rst after 2 bytes, then start and 4 bytes AA BB CC DD -> single write addr 0 data 0xDDCCBBAA.
REQ-038 The bench SHALL cover the following: with LOADER_PARITY_EN, byte 0x01 with parity bit 0 -> err=1, byte discarded; with parity bit 1 -> accepted.
